// File: rtl/block_route_ctrl.sv
// Sequencer for the 1-to-2 word demux feeding the ping-pong image banks.
// Steers BLOCK_LEN words to one bank, then flips, stalling while the target bank is still owned.
module block_route_ctrl #(
  parameter int WORD_SIZE = 16,
  parameter int BLOCK_LEN = 784,
  localparam int CNT_W = $clog2(BLOCK_LEN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 abort,
  output logic                 sel,
  output logic [WORD_SIZE-1:0] out_data_0,
  output logic [WORD_SIZE-1:0] out_data_1,
  output logic                 out_valid_0,
  output logic                 out_valid_1,
  input  logic                 out_ready_0,
  input  logic                 out_ready_1,
  output logic                 out_last_0,
  output logic                 out_last_1,
  input  logic                 release_0,
  input  logic                 release_1,
  output logic [1:0]           owned,
  output logic [CNT_W-1:0]     word_idx
);

  typedef enum logic {
    S_FILL    = 1'b0,
    S_BLOCKED = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       owned_q, owned_d;
  logic             fill;
  logic             tgt_ready;
  logic             at_last;
  logic             xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FILL;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
      owned_q <= 2'b00;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      owned_q <= owned_d;
    end
  end

  always_comb begin
    // rst_n gates the handshake so outputs are quiet for the whole reset pulse
    fill      = rst_n && (state_q == S_FILL);
    tgt_ready = sel_q ? out_ready_1 : out_ready_0;
    at_last   = (cnt_q == LAST_IDX);

    // in_ready is built without in_valid to keep the source handshake loop-free
    in_ready    = fill && tgt_ready;
    xfer        = in_valid && in_ready;
    out_valid_0 = fill && !sel_q && in_valid;
    out_valid_1 = fill &&  sel_q && in_valid;
    out_last_0  = fill && !sel_q && at_last;
    out_last_1  = fill &&  sel_q && at_last;
    out_data_0  = (rst_n && !sel_q) ? in_data : '0;
    out_data_1  = (rst_n &&  sel_q) ? in_data : '0;

    sel_d   = sel_q;
    cnt_d   = cnt_q;
    owned_d = owned_q;
    if (release_0) owned_d[0] = 1'b0;
    if (release_1) owned_d[1] = 1'b0;

    // abort wins over a same-cycle transfer: the word was offered but is not counted
    if (abort) begin
      cnt_d = '0;
    end else if (xfer) begin
      if (at_last) begin
        cnt_d          = '0;
        owned_d[sel_q] = 1'b1;
        sel_d          = ~sel_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    state_d = owned_d[sel_d] ? S_BLOCKED : S_FILL;
  end

  assign sel      = sel_q;
  assign owned    = owned_q;
  assign word_idx = cnt_q;

endmodule

// File: tb/tb_block_route_ctrl.sv
// Scoreboard bench for block_route_ctrl: driver pushes expectations from a block-level model,
// a negedge monitor pops and compares whenever the DUT hands a word to a bank.
module tb_block_route_ctrl;
  localparam int WS = 16;
  localparam int L  = 4;
  localparam int CW = $clog2(L);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [WS-1:0] in_data;
  logic          in_valid, in_ready, abort, sel;
  logic [WS-1:0] out_data_0, out_data_1;
  logic          out_valid_0, out_valid_1, out_ready_0, out_ready_1;
  logic          out_last_0, out_last_1, release_0, release_1;
  logic [1:0]    owned;
  logic [CW-1:0] word_idx;

  block_route_ctrl #(.WORD_SIZE(WS), .BLOCK_LEN(L)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .abort(abort), .sel(sel), .out_data_0(out_data_0), .out_data_1(out_data_1),
    .out_valid_0(out_valid_0), .out_valid_1(out_valid_1),
    .out_ready_0(out_ready_0), .out_ready_1(out_ready_1),
    .out_last_0(out_last_0), .out_last_1(out_last_1),
    .release_0(release_0), .release_1(release_1), .owned(owned), .word_idx(word_idx)
  );

  always #5 clk = ~clk;

  typedef struct { int bank; int data; int last; int idx; } word_t;
  typedef struct { int rdy; int sel; int owned; int idx; } stat_t;
  word_t word_q[$];
  stat_t stat_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model: which bank is filling, how many words it holds, which banks are full
  int     m_bank;
  int     m_fill;
  bit     m_full [2];
  int     next_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_word(input int b, input logic [WS-1:0] d, input logic lst);
    word_t w;
    if (word_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_word: bank %0d got data %0h expected no transfer", b, d);
    end else begin
      w = word_q.pop_front();
      chk("word_bank", b, w.bank);
      chk("word_data", d, w.data);
      chk("word_last", lst, w.last);
      chk("word_idx_at_xfer", word_idx, w.idx);
      $display("word bank=%0d data=%04h last=%0d idx=%0d", b, d, lst, word_idx);
    end
  endtask

  always @(negedge clk) begin
    stat_t s;
    if (rst_n) begin
      if (stat_q.size() != 0) begin
        s = stat_q.pop_front();
        chk("in_ready", in_ready, s.rdy);
        chk("sel", sel, s.sel);
        chk("owned", owned, s.owned);
        chk("word_idx", word_idx, s.idx);
        chk("idle_bank_data", sel ? out_data_0 : out_data_1, 0);
      end
      if (out_valid_0 && out_ready_0) check_word(0, out_data_0, out_last_0);
      if (out_valid_1 && out_ready_1) check_word(1, out_data_1, out_last_1);
    end
  end

  // One clock of stimulus; expectations come from the model before the edge
  task automatic cycle(input bit v, input bit r0, input bit r1,
                       input bit rl0, input bit rl1, input bit ab);
    bit    rdy, xf;
    stat_t s;
    word_t w;
    in_valid    = v;
    in_data     = WS'(next_word);
    out_ready_0 = r0;
    out_ready_1 = r1;
    release_0   = rl0;
    release_1   = rl1;
    abort       = ab;
    rdy = !m_full[m_bank] && ((m_bank == 1) ? r1 : r0);
    xf  = v && rdy;
    s.rdy   = int'(rdy);
    s.sel   = m_bank;
    s.owned = int'(m_full[0]) + 2 * int'(m_full[1]);
    s.idx   = m_fill;
    stat_q.push_back(s);
    if (xf) begin
      w.bank = m_bank;
      w.data = next_word;
      w.last = (m_fill == L - 1) ? 1 : 0;
      w.idx  = m_fill;
      word_q.push_back(w);
      next_word++;
    end
    @(posedge clk);
    if (rl0) m_full[0] = 1'b0;
    if (rl1) m_full[1] = 1'b0;
    if (ab) begin
      m_fill = 0;
    end else if (xf) begin
      m_fill++;
      if (m_fill == L) begin
        m_full[m_bank] = 1'b1;
        m_bank = 1 - m_bank;
        m_fill = 0;
      end
    end
    #1;
  endtask

  // Asynchronous reset applied mid-cycle, checked before any clock edge
  task automatic do_reset();
    in_valid    = 1'b1;
    out_ready_0 = 1'b1;
    out_ready_1 = 1'b1;
    release_0   = 1'b0;
    release_1   = 1'b0;
    abort       = 1'b0;
    rst_n       = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_valid", {out_valid_1, out_valid_0}, 0);
    chk("rst_last", {out_last_1, out_last_0}, 0);
    chk("rst_data", {out_data_1, out_data_0}, 0);
    chk("rst_idx", word_idx, 0);
    chk("rst_owned", owned, 0);
    chk("rst_sel", sel, 0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    m_bank   = 0;
    m_fill   = 0;
    m_full[0] = 1'b0;
    m_full[1] = 1'b0;
  endtask

  initial begin
    in_valid = 0; in_data = '0; abort = 0;
    out_ready_0 = 0; out_ready_1 = 0; release_0 = 0; release_1 = 0;
    next_word = 1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Two full blocks back to back: both banks end up owned
    for (int i = 0; i < 8; i++) cycle(1, 1, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    chk("both_owned", owned, 2'b11);
    chk("both_owned_ready", in_ready, 0);

    // Release bank 0 with the source waiting
    cycle(1, 1, 1, 1, 0, 0);
    chk("resume_ready", in_ready, 1);
    chk("resume_idx", word_idx, 0);
    chk("resume_sel", sel, 0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 0, 0, 0);

    // Completion of bank 0 together with release of bank 1
    cycle(1, 1, 1, 0, 1, 0);
    chk("simul_sel", sel, 1);
    chk("simul_owned", owned, 2'b01);
    chk("simul_ready_hi", in_ready, 1);
    out_ready_1 = 1'b0;
    #1;
    chk("simul_ready_lo", in_ready, 0);

    // Fill bank 1, free bank 0, then a block under toggling backpressure
    for (int i = 0; i < 4; i++) cycle(1, 1, 1, 0, 0, 0);
    cycle(1, 1, 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) cycle(1, (i % 2) == 0, 1, 0, 0, 0);
    chk("bp_owned", owned, 2'b11);
    chk("bp_sel", sel, 1);

    // Abort after two words: the block needs four fresh transfers
    do_reset();
    cycle(1, 1, 1, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 1);
    chk("abort_idx", word_idx, 0);
    chk("abort_sel", sel, 0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 0, 0, 0);
    chk("abort_not_done", owned, 2'b00);
    cycle(1, 1, 1, 0, 0, 0);
    chk("abort_done_owned", owned, 2'b01);
    chk("abort_done_sel", sel, 1);

    // Randomised traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0);

    // Reset in the middle of a block
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, 1, 1, 0, 0, 0);
    cycle(0, 1, 1, 1, 0, 0);
    cycle(1, 1, 1, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0);
    chk("mid_owned", owned, 2'b10);
    chk("mid_idx", word_idx, 2);
    do_reset();
    cycle(1, 1, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);

    chk("word_q_drained", word_q.size(), 0);
    chk("stat_q_drained", stat_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
